// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dmem_lsu data memory.
//   - size encodings for req_size (SZ_B, SZ_H, SZ_W, SZ_RSV)
//   - FSM state type (ST_INIT clear sweep, ST_RUN normal service)
//   - response-slot record
//   - lane-select, store-alignment and load-extension helpers
`timescale 1ns/1ps
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Everything needed to shape the read word once it leaves the RAM
  // read register, captured at the accept edge.
  typedef struct packed {
    logic       valid;
    logic       err;
    logic       load;   // load without error: rdata carries data
    logic       uns;
    logic [1:0] size;
    logic [1:0] lane;
  } rsp_t;

  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the right-aligned store data onto every lane; the byte
  // enables pick which copy lands.
  function automatic logic [31:0] store_align(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return uns ? {24'd0, $unsigned(b)} : 32'(b);
      SZ_H:    return uns ? {16'd0, $unsigned(h)} : 32'(h);
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bus between the core memory stage
// (master) and dmem_lsu (slave).
//   req_valid/req_ready   request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request payload
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_err  response payload
//   init_busy             clear sweep in progress
`timescale 1ns/1ps
interface dmem_lsu_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              init_busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, init_busy
  );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH_WORDS x 32 data array.
//   clk      clock
//   we_i     write enable, be_i per-byte enables
//   addr_i   word index, wdata_i write data
//   re_i     read enable; rdata_o is registered and only changes on re_i
// No reset: contents are undefined until written.
`timescale 1ns/1ps
module dmem_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  input  logic                           re_i,
  output logic [31:0]                    rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data memory with load/store sizing.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         dmem_lsu_if.slave: valid/ready request, one registered
//               response slot (resp_rdata/resp_err), init_busy
// Optional feature macro DMEM_CLEAR_EN: when defined, reset enters a
// clear sweep writing zero to every word (one per cycle) before service
// starts; when undefined, reset goes straight to service and init_busy=0.
`timescale 1ns/1ps
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  dmem_lsu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             req_err;
  logic             accept;
  logic             run;
  logic             sweep_we;
  logic [IDX_W-1:0] sweep_idx;
  rsp_t             slot_q, slot_d;
  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_addr;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata, ram_rdata;

  assign idx  = bus.req_addr[IDX_W+1:2];
  assign lane = bus.req_addr[1:0];

  assign req_err = (bus.req_size == SZ_RSV)
                || (bus.req_size == SZ_H && lane[0])
                || (bus.req_size == SZ_W && lane != 2'b00)
                || (|bus.req_addr[ADDR_W-1:IDX_W+2]);

`ifdef DMEM_CLEAR_EN
  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + IDX_W'(1);
        // Leave on the edge that writes the last word.
        if (&cnt_q) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign run           = (state_q == ST_RUN);
  assign sweep_idx     = cnt_q;
  assign bus.init_busy = (state_q == ST_INIT);
`else
  assign run           = 1'b1;
  assign sweep_we      = 1'b0;
  assign sweep_idx     = '0;
  assign bus.init_busy = 1'b0;
`endif

  // Ready depends only on state and resp_ready so the master may wait
  // for ready before raising valid without a combinational loop.
  assign bus.req_ready = run && (!slot_q.valid || bus.resp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // Erroneous requests never touch the array.
  assign ram_we    = sweep_we || (accept && bus.req_we && !req_err);
  assign ram_re    = accept && !bus.req_we && !req_err;
  assign ram_addr  = sweep_we ? sweep_idx : idx;
  assign ram_be    = sweep_we ? 4'hF : lane_be(bus.req_size, lane);
  assign ram_wdata = sweep_we ? 32'd0 : store_align(bus.req_size, bus.req_wdata);

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d.valid = 1'b1;
      slot_d.err   = req_err;
      slot_d.load  = !bus.req_we && !req_err;
      slot_d.uns   = bus.req_unsigned;
      slot_d.size  = bus.req_size;
      slot_d.lane  = lane;
    end else if (bus.resp_ready) begin
      slot_d.valid = 1'b0;
      slot_d.err   = 1'b0;
      slot_d.load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  // The RAM read register holds still under backpressure, so shaping it
  // combinationally keeps resp_rdata stable while the slot is held.
  assign bus.resp_valid = slot_q.valid;
  assign bus.resp_err   = slot_q.err;
  assign bus.resp_rdata = slot_q.load
                        ? load_extend(slot_q.size, slot_q.lane, slot_q.uns, ram_rdata)
                        : 32'd0;
endmodule

// File: tb/tb_dmem_lsu.sv
`timescale 1ns/1ps
module tb_dmem_lsu;
  localparam int DEPTH  = 256;
  localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(32)) bus ();
  dmem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: one byte per address.
  logic [7:0] mm [NBYTES];

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        eerr;
  } vec_t;

  // Behavioural reference: apply one request to the byte array and
  // return what the response must carry.
  task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int nb, a;
    longint v;
    nb = 1 << sz;
    er = (sz == 2'd3) || ((addr % nb) != 0) || (addr >= NBYTES);
    rd = 32'd0;
    if (er) return;
    a = int'(addr);
    if (we) begin
      for (int i = 0; i < nb; i++) mm[a+i] = 8'(wd >> (8*i));
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(mm[a+i]) << (8*i));
      if (!uns && nb < 4 && v >= (longint'(1) << (8*nb-1))) v = v - (longint'(1) << (8*nb));
      rd = 32'(v);
    end
  endtask

  // One request with resp_ready high; returns the response sampled in the
  // cycle after the accept edge. Starts and ends away from the rising edge.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output logic tmo);
    int n;
    tmo = 1'b0;
    rd = 32'd0;
    er = 1'b0;
    bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd;
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      tmo = 1'b1;
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    if (bus.resp_valid !== 1'b1) tmo = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    logic busy_ok;
    logic [31:0] rd, mrd;
    logic er, mer, tmo;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0
        || bus.init_busy !== CLR || (CLR && bus.req_ready !== 1'b0)) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b rdata=%h err=%b busy=%b ready=%b, required valid=0 rdata=0 err=0 busy=%b ready=0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.init_busy, bus.req_ready, CLR);
    end
    rst_n = 1'b1;
    #1;
    n = 0;
    busy_ok = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      if (bus.init_busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== (CLR ? DEPTH : 0)) begin
      n_fail++;
      $display("FAIL init_length: ready low for %0d cycles, required %0d", n, CLR ? DEPTH : 0);
    end
    n_checks++;
    if (!busy_ok || bus.init_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL init_busy: during_ok=%b after=%b, required during_ok=1 after=0", busy_ok, bus.init_busy);
    end
    for (int i = 0; i < NBYTES; i++) mm[i] = CLR ? 8'd0 : 8'bx;
    if (CLR) begin
      model_access(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, mrd, mer);
      txn(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, rd, er, tmo);
      n_checks++;
      if (tmo || rd !== 32'h0 || er !== 1'b0) begin
        n_fail++;
        $display("FAIL cleared_load: rdata=%h err=%b tmo=%b, required rdata=00000000 err=0", rd, er, tmo);
      end
    end
    // Give the low region known contents so random loads are comparable
    // whether or not the clear sweep is built in.
    for (int w = 0; w < 32; w++) begin
      logic [31:0] d;
      d = $urandom;
      model_access(1'b1, 2'd2, 1'b0, 32'(w*4), d, mrd, mer);
      txn(1'b1, 2'd2, 1'b0, 32'(w*4), d, rd, er, tmo);
      n_checks++;
      if (tmo || rd !== mrd || er !== mer) begin
        n_fail++;
        $display("FAIL preload_%0d: rdata=%h err=%b tmo=%b, required rdata=%h err=%b", w, rd, er, tmo, mrd, mer);
      end
    end
  endtask

  task automatic test_sign_ext();
    vec_t v[$];
    logic [31:0] rd, mrd;
    logic er, mer, tmo;
    v.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h00000000, 1'b0});
    v.push_back('{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000001, 1'b0});
    v.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0});
    v.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h000080FF, 1'b0});
    v.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0});
    v.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0});
    v.push_back('{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h00007F01, 1'b0});
    v.push_back('{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        32'h80FF7F01, 1'b0});
    foreach (v[i]) begin
      model_access(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wd, mrd, mer);
      txn(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wd, rd, er, tmo);
      n_checks++;
      if (tmo || rd !== v[i].exp || er !== v[i].eerr) begin
        n_fail++;
        $display("FAIL sign_ext_%0d: rdata=%h err=%b tmo=%b, required rdata=%h err=%b", i, rd, er, tmo, v[i].exp, v[i].eerr);
      end
    end
  endtask

  task automatic test_byte_merge();
    vec_t v[$];
    logic [31:0] rd, mrd;
    logic er, mer, tmo;
    v.push_back('{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0,        1'b0});
    v.push_back('{1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFFAB, 32'h0,        1'b0});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h1122AB44, 1'b0});
    v.push_back('{1'b1, 2'd1, 1'b0, 32'h22, 32'h99995566, 32'h0,        1'b0});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h5566AB44, 1'b0});
    foreach (v[i]) begin
      model_access(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wd, mrd, mer);
      txn(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wd, rd, er, tmo);
      n_checks++;
      if (tmo || rd !== v[i].exp || er !== v[i].eerr) begin
        n_fail++;
        $display("FAIL byte_merge_%0d: rdata=%h err=%b tmo=%b, required rdata=%h err=%b", i, rd, er, tmo, v[i].exp, v[i].eerr);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[$];
    logic [31:0] rd, mrd;
    logic er, mer, tmo;
    v.push_back('{1'b1, 2'd2, 1'b0, 32'h00,       32'h0BADCAFE, 32'h0,        1'b0});
    v.push_back('{1'b1, 2'd2, 1'b0, 32'h04,       32'h01020304, 32'h0,        1'b0});
    v.push_back('{1'b1, 2'd2, 1'b0, 32'h08,       32'hA5A5A5A5, 32'h0,        1'b0});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h22,       32'h0,        32'h0,        1'b1});
    v.push_back('{1'b1, 2'd1, 1'b0, 32'h05,       32'h0000FFFF, 32'h0,        1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h04,       32'h0,        32'h01020304, 1'b0});
    v.push_back('{1'b1, 2'd3, 1'b0, 32'h08,       32'hFFFFFFFF, 32'h0,        1'b1});
    v.push_back('{1'b0, 2'd3, 1'b0, 32'h08,       32'h0,        32'h0,        1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h08,       32'h0,        32'hA5A5A5A5, 1'b0});
    v.push_back('{1'b1, 2'd2, 1'b0, 32'h400,      32'hCAFEF00D, 32'h0,        1'b1});
    v.push_back('{1'b0, 2'd0, 1'b1, 32'h401,      32'h0,        32'h0,        1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h80000000, 32'h0,        32'h0,        1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, 32'h00,       32'h0,        32'h0BADCAFE, 1'b0});
    v.push_back('{1'b0, 2'd1, 1'b1, 32'h03,       32'h0,        32'h0,        1'b1});
    foreach (v[i]) begin
      model_access(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wd, mrd, mer);
      txn(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wd, rd, er, tmo);
      n_checks++;
      if (tmo || rd !== v[i].exp || er !== v[i].eerr) begin
        n_fail++;
        $display("FAIL errors_%0d: rdata=%h err=%b tmo=%b, required rdata=%h err=%b", i, rd, er, tmo, v[i].exp, v[i].eerr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mrd;
    logic mer;
    model_access(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, mrd, mer);
    model_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, mrd, mer);
    bus.resp_ready = 1'b1;
    bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'hDEADBEEF;
    bus.req_valid = 1'b1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: req_ready=%b, required 1", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_we = 1'b0; bus.req_wdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b rdata=%h err=%b ready=%b, required valid=1 rdata=00000000 err=0 ready=1",
               bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF || bus.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b rdata=%h err=%b, required valid=1 rdata=deadbeef err=0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] mrd;
    logic mer;
    model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mrd, mer);
    model_access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, mrd, mer);
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0; bus.req_addr = 32'h10;
    bus.req_valid = 1'b1;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #1 bus.req_size = 2'd1; bus.req_addr = 32'h12;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h80FF7F01 || bus.resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: ready=%b valid=%b rdata=%h err=%b, required ready=0 valid=1 rdata=80ff7f01 err=0",
                 k, bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFF80FF || bus.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b rdata=%h err=%b, required valid=1 rdata=ffff80ff err=0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: valid=%b, required 0", bus.resp_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    logic [31:0] rd, mrd, exp;
    logic er, mer, tmo;
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0; bus.req_addr = 32'h40;
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rst_pending: valid=%b rdata=%h, required valid=1 rdata=deadbeef", bus.resp_valid, bus.resp_rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0 || (CLR && bus.req_ready !== 1'b0)) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b rdata=%h err=%b ready=%b, required valid=0 rdata=0 err=0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== (CLR ? DEPTH : 0)) begin
      n_fail++;
      $display("FAIL rst_reinit: ready low for %0d cycles, required %0d", n, CLR ? DEPTH : 0);
    end
    if (CLR) for (int i = 0; i < NBYTES; i++) mm[i] = 8'd0;
    model_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, exp, mer);
    txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, tmo);
    n_checks++;
    if (tmo || rd !== exp || er !== mer) begin
      n_fail++;
      $display("FAIL rst_mem: rdata=%h err=%b tmo=%b, required rdata=%h err=%b", rd, er, tmo, exp, mer);
    end
    mrd = rd;
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, addr, wd;
    logic er, mer, tmo, we, uns;
    logic [1:0] sz;
    int r;
    for (int i = 0; i < 300; i++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 15);
      sz  = (r == 0) ? 2'd3 : 2'(r % 3);
      if ($urandom_range(0, 19) == 0) addr = $urandom | 32'h400;
      else                            addr = 32'($urandom_range(0, 127));
      wd = $urandom;
      model_access(we, sz, uns, addr, wd, mrd, mer);
      txn(we, sz, uns, addr, wd, rd, er, tmo);
      n_checks++;
      if (tmo || rd !== mrd || er !== mer) begin
        n_fail++;
        $display("FAIL random_%0d (we=%b sz=%0d uns=%b addr=%h): rdata=%h err=%b tmo=%b, required rdata=%h err=%b",
                 i, we, sz, uns, addr, rd, er, tmo, mrd, mer);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sign_ext();
    test_byte_merge();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
